// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types for the serial magnitude comparator.
//               Holds the control FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Control FSM of magcompare_serial.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for operands
    SCAN = 2'd1,  // walking digits MSB-first
    DONE = 2'd2   // result presented, waiting for consumer
  } statetype_t;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/magcompare_digit.sv
`default_nettype none
// ============================================================================
// Module      : magcompare_digit
// Description : Combinational unsigned compare of two DIGIT-bit digits.
//               Equality is derived by the caller as ~(o_lt | o_gt).
// Ports       : i_a, i_b  - digits to compare
//               o_lt      - i_a < i_b (unsigned)
//               o_gt      - i_a > i_b (unsigned)
// Revision    : 1.0 - initial release
// ============================================================================
module magcompare_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_lt,
  output logic             o_gt
);

  assign o_lt = (i_a < i_b);
  assign o_gt = (i_a > i_b);

endmodule : magcompare_digit
`default_nettype wire

// File: rtl/magcompare_serial.sv
`default_nettype none
// ============================================================================
// Module      : magcompare_serial
// Description : Iterative MSB-first magnitude comparator. Scans two WIDTH-bit
//               operands one DIGIT-bit digit per cycle and stops at the first
//               differing digit. Produces EQ, signed LT and unsigned LTu.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               InValid/InReady - operand handshake (A, B)
//               OutValid/OutReady - result handshake (EQ, LT, LTu)
// Revision    : 1.0 - initial release
// ============================================================================
module magcompare_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             EQ,
  output logic             LT,
  output logic             LTu
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG);

  localparam logic [CW-1:0] c_CNT_LAST = CW'(NDIG - 1);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] c_CNT_ZERO = '0;

  statetype_t       r_state;
  statetype_t       w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_eq;
  logic             r_lt;
  logic             r_ltu;

  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic             w_dig_lt;
  logic             w_dig_gt;
  logic             w_dig_eq;
  logic             w_msb_differ;
  logic             w_last_dig;

  // --------------------------------------------------------------------------
  // Current digit selection and compare
  // --------------------------------------------------------------------------
  always_comb begin
    w_dig_a = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    w_dig_b = r_b[int'(r_cnt) * DIGIT +: DIGIT];
  end

  magcompare_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a  (w_dig_a),
    .i_b  (w_dig_b),
    .o_lt (w_dig_lt),
    .o_gt (w_dig_gt)
  );

  assign w_dig_eq     = ~(w_dig_lt | w_dig_gt);
  assign w_last_dig   = (r_cnt == c_CNT_ZERO);
  // When the sign bits differ the negative operand is the smaller one,
  // regardless of what the unsigned scan found.
  assign w_msb_differ = r_a[WIDTH-1] ^ r_b[WIDTH-1];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (InValid) begin
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (!w_dig_eq || w_last_dig) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand capture, digit counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= c_CNT_ZERO;
      r_out_valid <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
    end else begin
      // OutValid is a registered copy of "next state is DONE".
      r_out_valid <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (InValid) begin
            r_a   <= A;
            r_b   <= B;
            r_cnt <= c_CNT_LAST;
          end
        end
        SCAN: begin
          if (!w_dig_eq) begin
            r_eq  <= 1'b0;
            r_ltu <= w_dig_lt;
            r_lt  <= w_msb_differ ? r_a[WIDTH-1] : w_dig_lt;
          end else if (w_last_dig) begin
            r_eq  <= 1'b1;
            r_ltu <= 1'b0;
            r_lt  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          // DONE: flags held until the consumer takes them
        end
      endcase
    end
  end

  assign InReady  = (r_state == IDLE);
  assign OutValid = r_out_valid;
  assign EQ       = r_eq;
  assign LT       = r_lt;
  assign LTu      = r_ltu;

endmodule : magcompare_serial
`default_nettype wire

// File: tb/tb_magcompare_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_magcompare_serial
// Description : Self-checking bench for magcompare_serial (WIDTH=64, DIGIT=2).
//               Directed vector table, hand-written reset / operand-churn
//               sequences, and random operands checked against a reference
//               model built from plain arithmetic compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_magcompare_serial;

  localparam int WIDTH = 64;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk;
  logic             reset;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic             OutReady;
  logic             EQ;
  logic             LT;
  logic             LTu;

  int n_cmp;
  int n_bad;

  magcompare_serial #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .EQ       (EQ),
    .LT       (LT),
    .LTu      (LTu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               hold;
    logic             eq;
    logic             lt;
    logic             ltu;
    int               lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: flags from native compares, latency from the position
  // of the most significant differing digit.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic eq, output logic lt, output logic ltu,
                                output int lat);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] mask;
    eq   = (a == b);
    ltu  = (a < b);
    lt   = ($signed(a) < $signed(b));
    x    = a ^ b;
    mask = (64'd1 << DIGIT) - 64'd1;
    lat  = NDIG;
    for (int d = NDIG - 1; d >= 0; d--) begin
      if (((x >> (d * DIGIT)) & mask) != 0) begin
        lat = NDIG - d;
        break;
      end
    end
  endfunction

  // One full transaction: accept, measure latency, hold result for 'hold'
  // cycles with OutReady low, then handshake. With 'churn' set, A/B are
  // scrambled and InValid held high during the scan.
  task automatic do_compare(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int hold, input bit churn,
                            input logic eeq, input logic elt, input logic eltu, input int elat);
    int  lat;
    bit  timed_out;
    @(negedge clk);
    chk({tag, " InReady idle"}, 64'(InReady), 64'd1);
    A       = a;
    B       = b;
    InValid = 1'b1;
    @(posedge clk);
    #1;
    if (!churn) InValid = 1'b0;
    lat       = 0;
    timed_out = 1'b0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (OutValid) break;
      if (churn) begin
        chk({tag, " InReady busy"}, 64'(InReady), 64'd0);
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
      end
      if (lat > 2 * NDIG) begin
        timed_out = 1'b1;
        break;
      end
    end
    InValid = 1'b0;
    if (timed_out) begin
      chk({tag, " OutValid timeout"}, 64'(OutValid), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " EQ"}, 64'(EQ), 64'(eeq));
    chk({tag, " LT"}, 64'(LT), 64'(elt));
    chk({tag, " LTu"}, 64'(LTu), 64'(eltu));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold {OutValid,InReady,EQ,LT,LTu}"},
          64'({OutValid, InReady, EQ, LT, LTu}),
          64'({1'b1, 1'b0, eeq, elt, eltu}));
    end
    OutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    OutReady = 1'b0;
    chk({tag, " post-handshake {OutValid,InReady}"}, 64'({OutValid, InReady}), 64'b01);
    if (churn) begin
      // InValid low now: the block must stay idle.
      @(negedge clk);
      chk({tag, " stays idle"}, 64'({OutValid, InReady}), 64'b01);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vec_t       v;
    logic       meq, mlt, mltu;
    int         mlat;
    logic [WIDTH-1:0] ra, rb;
    int         mode;

    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    A        = '0;
    B        = '0;

    //          a                       b                       hold eq lt ltu lat
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 0, 0, 1, 0, 1});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 0, 32});
    vecs.push_back('{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0006, 0, 0, 1, 1, 32});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10, 0, 0, 1, 1});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 2, 0, 1, 0, 1});
    vecs.push_back('{64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000, 1, 0, 0, 0, 16});
    vecs.push_back('{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0010, 0, 0, 1, 1, 30});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 1, 32});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset {InReady,OutValid,EQ,LT,LTu}",
        64'({InReady, OutValid, EQ, LT, LTu}), 64'b10000);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_compare($sformatf("vec%0d", i), v.a, v.b, v.hold, 1'b0, v.eq, v.lt, v.ltu, v.lat);
    end

    // Reset in SCAN cycle 5 of an equal-operand compare.
    @(negedge clk);
    A       = 64'h0123_4567_89AB_CDEF;
    B       = 64'h0123_4567_89AB_CDEF;
    InValid = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid-scan reset {InReady,OutValid,EQ,LT,LTu}",
        64'({InReady, OutValid, EQ, LT, LTu}), 64'b10000);
    do_compare("after-reset 3v2", 64'd3, 64'd2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32);

    // Operand churn during scan: result follows captured operands.
    model(64'h8000_0000_0000_00F0, 64'h8000_0000_0000_0F00, meq, mlt, mltu, mlat);
    do_compare("churn", 64'h8000_0000_0000_00F0, 64'h8000_0000_0000_0F00, 2, 1'b1,
               meq, mlt, mltu, mlat);

    // Random operands against the reference model.
    for (int n = 0; n < 120; n++) begin
      ra   = {$urandom, $urandom};
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rb = {$urandom, $urandom};
        1:       rb = ra;
        2:       rb = ra ^ (64'd1 << $urandom_range(0, WIDTH - 1));
        default: rb = ra ^ ({$urandom, $urandom} >> $urandom_range(0, WIDTH - 1));
      endcase
      model(ra, rb, meq, mlt, mltu, mlat);
      do_compare($sformatf("rnd%0d", n), ra, rb, $urandom_range(0, 3), (n % 16) == 7,
                 meq, mlt, mltu, mlat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_magcompare_serial
`default_nettype wire
